// File: rtl/fifo_arb_pkg.sv
// Types shared by the FIFO write arbiter and the read-side schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority finder: first set request at or above ptr, wrapping at nreq-1.
module rr_pick #(
    parameter  int nreq = 4,
    localparam int IW   = (nreq > 1) ? $clog2(nreq) : 1
) (
    input  logic [nreq-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        logic [IW:0]   sum_s;
        logic [IW-1:0] cand_s;
        any    = 1'b0;
        idx    = '0;
        sum_s  = '0;
        cand_s = '0;
        for (int k = nreq - 1; k >= 0; k--) begin
            sum_s = {1'b0, ptr} + (IW+1)'(k);
            if (sum_s >= (IW+1)'(nreq)) begin
                sum_s = sum_s - (IW+1)'(nreq);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IW-1:0];
            if (req[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between nreq burst requesters;
// a grant is held for a whole burst (LAST or maxburst beats).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width    = 32,
    parameter int nreq     = 4,
    parameter int maxburst = 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [nreq-1:0]           REQ_VALID,
    input  logic [nreq-1:0]           REQ_LAST,
    input  logic [nreq*width-1:0]     REQ_DATA,
    output logic [nreq-1:0]           REQ_READY,
    output logic [width-1:0]          FIFO_D,
    output logic                      FIFO_WR,
    input  logic                      FIFO_FULL,
    output logic [$clog2(nreq)-1:0]   GNT_ID,
    output logic                      BUSY
);

    localparam int IW = $clog2(nreq);
    localparam int CW = $clog2(maxburst + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic          pick_any_s;
    logic [IW-1:0] pick_idx_s;
    logic          beat_s;
    logic          release_s;

    rr_pick #(
        .nreq (nreq)
    ) u_pick (
        .req (REQ_VALID),
        .ptr (ptr_q),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Accepted beat of the granted requester and whether it ends the grant.
    always_comb begin
        beat_s    = 1'b0;
        release_s = 1'b0;
        if (state_q == ARB_GRANT) begin
            beat_s    = REQ_VALID[gnt_q] & ~FIFO_FULL;
            release_s = beat_s & (REQ_LAST[gnt_q] | (cnt_q == CW'(maxburst - 1)));
        end else begin
            beat_s    = 1'b0;
            release_s = 1'b0;
        end
    end

    // Next-state logic for the grant FSM, pointer, grant index and beat counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    gnt_d   = pick_idx_s;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (beat_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (release_s) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (gnt_q == IW'(nreq - 1)) ? '0 : gnt_q + IW'(1);
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d == ARB_GRANT);
    end

    // Datapath steering; ready follows FULL combinationally, which is loop-free
    // because FULL comes straight from FIFO registers.
    always_comb begin
        REQ_READY = '0;
        FIFO_D    = '0;
        FIFO_WR   = 1'b0;
        if (state_q == ARB_GRANT) begin
            for (int i = 0; i < nreq; i++) begin
                if (gnt_q == IW'(i)) begin
                    REQ_READY[i] = ~FIFO_FULL;
                    FIFO_D       = REQ_DATA[i*width +: width];
                end else begin
                    REQ_READY[i] = 1'b0;
                end
            end
            FIFO_WR = beat_s;
        end else begin
            REQ_READY = '0;
            FIFO_D    = '0;
            FIFO_WR   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT_ID = gnt_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle compare against a queue-level
// arbitration model plus literal checks of grant order, burst sizes and data.
module tb_fifo_wr_arbiter;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int MB    = 8;
    localparam int DEPTH = 16;

    logic           CLK = 1'b0;
    logic           nRST;
    logic [N-1:0]   REQ_VALID, REQ_LAST, REQ_READY;
    logic [N*W-1:0] REQ_DATA;
    logic [W-1:0]   FIFO_D;
    logic           FIFO_WR, FIFO_FULL, BUSY;
    logic [1:0]     GNT_ID;

    fifo_wr_arbiter #(.width(W), .nreq(N), .maxburst(MB)) dut (
        .CLK(CLK), .nRST(nRST), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST),
        .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .FIFO_D(FIFO_D),
        .FIFO_WR(FIFO_WR), .FIFO_FULL(FIFO_FULL), .GNT_ID(GNT_ID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0, cyc = 0;

    logic [W-1:0] src_d [N][32];
    bit           src_l [N][32];
    int           head [N], tail [N];
    bit           hold [N];
    bit           acc  [N];

    logic [W-1:0] fifo_q [$];
    bit           drain_all;
    int           pop_req;
    logic         wr_s;
    logic [W-1:0] d_s;

    int           glog [$], blog [$], wcyc [$];
    logic [W-1:0] wlog [$];
    int           beats;
    bit           prev_busy;

    bit m_known = 1'b0, m_busy = 1'b0;
    int m_g = 0, m_cnt = 0, m_ptr = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gi(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction
    function automatic int bi(input int i);
        return (i < blog.size()) ? blog[i] : -1;
    endfunction
    function automatic logic [W-1:0] wi(input int i);
        return (i < wlog.size()) ? wlog[i] : 'x;
    endfunction
    function automatic int ci(input int i);
        return (i < wcyc.size()) ? wcyc[i] : -1;
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int r = 0; r < N; r++) p = p | (head[r] < tail[r]);
        return p;
    endfunction

    task automatic push_word(input int r, input logic [W-1:0] d, input bit l);
        src_d[r][tail[r]] = d;
        src_l[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic drive();
        logic [N*W-1:0] dv;
        dv = '0;
        for (int r = 0; r < N; r++) begin
            if (head[r] < tail[r] && !hold[r]) begin
                REQ_VALID[r] = 1'b1;
                REQ_LAST[r]  = src_l[r][head[r]];
                dv = dv | ((N*W)'(src_d[r][head[r]]) << (r*W));
            end else begin
                REQ_VALID[r] = 1'b0;
                REQ_LAST[r]  = 1'b0;
            end
        end
        REQ_DATA = dv;
    endtask

    // Compare DUT against the model, log DUT activity, then advance the model
    // to the state it must hold after the coming rising edge.
    task automatic sample_and_model();
        if (m_known) begin
            chk("busy",  BUSY, m_busy);
            chk("ready", REQ_READY, (m_busy && !FIFO_FULL) ? (32'd1 << m_g) : 32'd0);
            chk("wr",    FIFO_WR, m_busy && REQ_VALID[m_g] && !FIFO_FULL);
            chk("data",  FIFO_D, m_busy ? W'(REQ_DATA >> (m_g*W)) : 32'd0);
            if (m_busy) chk("gnt_id", GNT_ID, m_g);
        end
        if (BUSY === 1'b1 && !prev_busy) glog.push_back(int'(GNT_ID));
        if (FIFO_WR === 1'b1) begin
            beats++;
            wlog.push_back(FIFO_D);
            wcyc.push_back(cyc);
        end
        if (BUSY !== 1'b1 && prev_busy) begin
            blog.push_back(beats);
            beats = 0;
        end
        prev_busy = (BUSY === 1'b1);
        for (int r = 0; r < N; r++) acc[r] = (REQ_VALID[r] & REQ_READY[r]) === 1'b1;
        wr_s = FIFO_WR;
        d_s  = FIFO_D;

        if (!nRST) begin
            m_known = 1'b1; m_busy = 1'b0; m_ptr = 0; m_g = 0; m_cnt = 0;
        end else if (m_known && !m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (REQ_VALID[c]) begin
                    m_g = c; m_busy = 1'b1; m_cnt = 0;
                    break;
                end
            end
        end else if (m_known && REQ_VALID[m_g] && !FIFO_FULL) begin
            m_cnt++;
            if (REQ_LAST[m_g] || m_cnt == MB) begin
                m_busy = 1'b0;
                m_ptr  = (m_g + 1) % N;
            end
        end
    endtask

    task automatic apply();
        cyc++;
        for (int r = 0; r < N; r++) if (acc[r]) head[r]++;
        if (wr_s === 1'b1) fifo_q.push_back(d_s);
        if (drain_all || pop_req > 0) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (pop_req > 0) pop_req--;
        end
        FIFO_FULL = (fifo_q.size() >= DEPTH);
    endtask

    task automatic tick();
        drive();
        @(negedge CLK);
        sample_and_model();
        @(posedge CLK);
        #1;
        apply();
    endtask

    task automatic clear_logs();
        glog.delete(); blog.delete(); wlog.delete(); wcyc.delete();
        beats = 0;
        prev_busy = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        for (int r = 0; r < N; r++) begin
            head[r] = 0; tail[r] = 0; hold[r] = 1'b0;
        end
        fifo_q.delete();
        FIFO_FULL = 1'b0;
        drain_all = 1'b1;
        pop_req   = 0;
        clear_logs();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((pending() || m_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", (pending() || m_busy) ? 32'd1 : 32'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_writes(input int nw, input int budget);
        int n = 0;
        while (wlog.size() < nw && n < budget) begin
            tick();
            n++;
        end
        chk("write_timeout", (wlog.size() < nw) ? 32'd1 : 32'd0, 32'd0);
    endtask

    initial begin
        int start;
        nRST = 1'b0; FIFO_FULL = 1'b0; REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0;
        drain_all = 1'b1; pop_req = 0; beats = 0; prev_busy = 1'b0;
        for (int r = 0; r < N; r++) begin
            head[r] = 0; tail[r] = 0; hold[r] = 1'b0; acc[r] = 1'b0;
        end

        // Reset state
        do_reset();
        chk("rst_busy",  BUSY, 32'd0);
        chk("rst_ready", REQ_READY, 32'd0);
        chk("rst_wr",    FIFO_WR, 32'd0);
        chk("rst_d",     FIFO_D, 32'd0);

        // Single requester: A,B,C from req 2 on consecutive cycles
        push_word(2, 32'h0000_00A0, 1'b0);
        push_word(2, 32'h0000_00B0, 1'b0);
        push_word(2, 32'h0000_00C0, 1'b1);
        start = cyc;
        run_idle(20);
        chk("single_nwr", wlog.size(), 32'd3);
        chk("single_w0", wi(0), 32'h0000_00A0);
        chk("single_w1", wi(1), 32'h0000_00B0);
        chk("single_w2", wi(2), 32'h0000_00C0);
        chk("single_c0", ci(0), start + 1);
        chk("single_c2", ci(2), start + 3);
        chk("single_gnt", gi(0), 32'd2);
        chk("single_len", bi(0), 32'd3);
        chk("single_busy_end", BUSY, 32'd0);

        // Fairness: all four with two 2-beat bursts each
        do_reset();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 4; k++) push_word(r, 32'h100 * r + k, (k % 2) == 1);
        run_idle(60);
        chk("fair_ngnt", glog.size(), 32'd8);
        chk("fair_g0", gi(0), 32'd0);
        chk("fair_g1", gi(1), 32'd1);
        chk("fair_g2", gi(2), 32'd2);
        chk("fair_g3", gi(3), 32'd3);
        chk("fair_g4", gi(4), 32'd0);
        chk("fair_len", bi(0), 32'd2);

        // maxburst cut, req 3 interleaved between req 1 chunks
        do_reset();
        for (int k = 0; k < 20; k++) push_word(1, 32'h1000 + k, k == 19);
        for (int k = 0; k < 4; k++) push_word(3, 32'h3000 + k, (k % 2) == 1);
        run_idle(80);
        chk("mb_g0", gi(0), 32'd1);
        chk("mb_g1", gi(1), 32'd3);
        chk("mb_g2", gi(2), 32'd1);
        chk("mb_g3", gi(3), 32'd3);
        chk("mb_g4", gi(4), 32'd1);
        chk("mb_b0", bi(0), 32'd8);
        chk("mb_b2", bi(2), 32'd8);
        chk("mb_b4", bi(4), 32'd4);
        chk("mb_nwr", wlog.size(), 32'd24);

        // FULL stall: no drain, 20 words into a 16-deep FIFO
        do_reset();
        drain_all = 1'b0;
        for (int k = 0; k < 20; k++) push_word(0, 32'h5000 + k, k == 19);
        for (int k = 0; k < 40; k++) tick();
        chk("full_nwr16", wlog.size(), 32'd16);
        chk("full_flag", FIFO_FULL, 32'd1);
        chk("full_ready0", REQ_READY, 32'd0);
        chk("full_wr0", FIFO_WR, 32'd0);
        pop_req = 4;
        run_idle(60);
        chk("full_nwr20", wlog.size(), 32'd20);
        chk("full_w16", wi(16), 32'h5010);
        chk("full_w17", wi(17), 32'h5011);
        chk("full_w18", wi(18), 32'h5012);
        chk("full_w19", wi(19), 32'h5013);

        // Reset during the 3rd beat of req 2
        do_reset();
        for (int k = 0; k < 6; k++) push_word(2, 32'h6000 + k, k == 5);
        wait_writes(2, 20);
        chk("mid_busy_pre", BUSY, 32'd1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        chk("mid_busy",  BUSY, 32'd0);
        chk("mid_ready", REQ_READY, 32'd0);
        chk("mid_wr",    FIFO_WR, 32'd0);
        chk("mid_d",     FIFO_D, 32'd0);
        glog.delete();
        push_word(0, 32'h6100, 1'b0);
        push_word(0, 32'h6101, 1'b1);
        run_idle(40);
        chk("mid_g0", gi(0), 32'd0);
        chk("mid_g1", gi(1), 32'd2);

        // Valid gap on req 1 while req 0 waits
        do_reset();
        for (int k = 0; k < 5; k++) push_word(1, 32'h7000 + k, k == 4);
        tick();
        push_word(0, 32'h7100, 1'b0);
        push_word(0, 32'h7101, 1'b1);
        wait_writes(2, 20);
        hold[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("gap_nwr", wlog.size(), 32'd2);
        chk("gap_gnt", GNT_ID, 32'd1);
        chk("gap_busy", BUSY, 32'd1);
        hold[1] = 1'b0;
        run_idle(40);
        chk("gap_g0", gi(0), 32'd1);
        chk("gap_g1", gi(1), 32'd0);
        chk("gap_b0", bi(0), 32'd5);
        chk("gap_w2", wi(2), 32'h7002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
